// File: rtl/bnn_weight_streamer_if.sv
// Weight byte handshake plus the nibble/strobe load bus that feeds the BNN core.
// The streamer is the slave of the byte handshake and drives the load bus.
interface bnn_weight_streamer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] load_nibble;
    logic       load_en;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  load_nibble,
        input  load_en
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output load_nibble,
        output load_en
    );
endinterface

// File: rtl/bnn_weight_streamer.sv
// Serialises weight bytes onto the BNN core's 4-bit load bus, low nibble first, and
// stops after exactly NUM_NEURONS bytes so the core's neuron index stays aligned.
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 20,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic                 abort,
    bnn_weight_streamer_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LO,
        S_HI,
        S_GAP,
        S_FIN
    } state_e;

    localparam logic [4:0] LastCount = 5'(NUM_NEURONS);
    localparam logic [3:0] GapLast   = 4'(GAP_CYCLES - 1);
    localparam bit         UseGap    = (GAP_CYCLES > 0);

    state_e     state_d, state_q;
    logic [7:0] dataByte_d, dataByte_q;
    logic [4:0] byteCount_d, byteCount_q;
    logic [3:0] gapCount_d, gapCount_q;
    logic [4:0] countInc;

    logic       ready_q;
    logic       loadEn_q;
    logic [3:0] nibble_q;
    logic       busy_q;
    logic       done_q;

    assign countInc = byteCount_q + 5'd1;

    // Abort bypasses ena. Aborting between LO and the end of HI leaves the core holding
    // half a byte; only a core reset recovers from that.
    always_comb begin
        state_d     = state_q;
        dataByte_d  = dataByte_q;
        byteCount_d = byteCount_q;
        gapCount_d  = gapCount_q;
        if (abort) begin
            state_d    = S_IDLE;
            gapCount_d = 4'd0;
        end else if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_FETCH;
                        byteCount_d = 5'd0;
                    end
                end
                S_FETCH: begin
                    if (bus.in_valid) begin
                        dataByte_d = bus.in_data;
                        state_d    = S_LO;
                    end
                end
                S_LO: state_d = S_HI;
                S_HI: begin
                    byteCount_d = countInc;
                    gapCount_d  = 4'd0;
                    if (countInc == LastCount) begin
                        state_d = S_FIN;
                    end else if (UseGap) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_GAP: begin
                    if (gapCount_q == GapLast) begin
                        state_d    = S_FETCH;
                        gapCount_d = 4'd0;
                    end else begin
                        gapCount_d = gapCount_q + 4'd1;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they come straight out of flops and
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dataByte_q  <= 8'd0;
            byteCount_q <= 5'd0;
            gapCount_q  <= 4'd0;
            ready_q     <= 1'b0;
            loadEn_q    <= 1'b0;
            nibble_q    <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dataByte_q  <= dataByte_d;
            byteCount_q <= byteCount_d;
            gapCount_q  <= gapCount_d;
            ready_q     <= (state_d == S_FETCH);
            loadEn_q    <= (state_d == S_LO) || (state_d == S_HI);
            nibble_q    <= (state_d == S_LO) ? dataByte_d[3:0] :
                           (state_d == S_HI) ? dataByte_d[7:4] : 4'd0;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.load_en     = loadEn_q;
    assign bus.load_nibble = nibble_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign byte_count      = byteCount_q;

endmodule
